key_mapper: RTL and testbench

- Sits directly upstream of the player blocks.
- Receives HID boot-keyboard keycode bytes from the USB/SPI host interface and assembles them into per-report key masks.
- Publishes a frame-stable 8-bit direction mask, Keycode, consumed by both player instances, plus a start-key edge pulse for the game FSM.
- Keycode is updated only on the frame boundary, so every player frame sees one consistent input snapshot.

---
 rtl/key_mapper_if.sv | 22 ++
 rtl/key_mapper.sv | 171 +++++++++++++++++
 tb/tb_key_mapper.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_mapper_if.sv
// HID keycode byte stream from the host interface into key_mapper.
// A byte moves on a cycle where ReportValid && ReportReady.
interface key_mapper_if;
    logic       ReportValid;
    logic       ReportReady;
    logic [7:0] ReportByte;
    logic       ReportLast;

    modport master (
        output ReportValid,
        output ReportByte,
        output ReportLast,
        input  ReportReady
    );

    modport slave (
        input  ReportValid,
        input  ReportByte,
        input  ReportLast,
        output ReportReady
    );
endinterface

// File: rtl/key_mapper.sv
// key_mapper: folds HID boot-keyboard reports into a 9-bit key mask
// (8 directions + start) and publishes it once per frame on Keycode,
// with a start-key edge pulse. Reports with a rollover code are dropped,
// and keys read as released after TIMEOUT_CYCLES without a good report.
// Optional macro KEY_STICKY_EN: reports committed within one frame are
// ORed, so a tap shorter than a frame is still seen for one frame.
module key_mapper #(
    parameter int unsigned NUM_SLOTS      = 6,
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  logic         Clk,
    input  logic         Reset_n,
    key_mapper_if.slave  rpt,
    input  logic         FrameStart,
    output logic [7:0]   Keycode,
    output logic         StartPulse,
    output logic         Overflow
);

    localparam int unsigned CW = $clog2(NUM_SLOTS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {COLLECT, COMMIT} state_t;

    state_t          state_q, state_d;
    logic [8:0]      acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            discard_q, discard_d;
    logic [8:0]      pending_q, pending_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            prev_start_q, prev_start_d;
    logic [7:0]      key_q, key_d;
    logic            sp_q, sp_d;
    logic            ovf_q, ovf_d;
`ifdef KEY_STICKY_EN
    logic [8:0]      last_q, last_d;
`endif

    logic xfer;
    logic commit_ok;
    logic tmo_hit;

    // Mask layout: [8] start, [7:4] P1 {L,R,U,D}, [3:0] P2 {L,R,U,D}.
    function automatic logic [8:0] map_key(input logic [7:0] code);
        logic [8:0] m;
        m = '0;
        case (code)
            8'h04: m[7] = 1'b1;
            8'h07: m[6] = 1'b1;
            8'h1A: m[5] = 1'b1;
            8'h16: m[4] = 1'b1;
            8'h50: m[3] = 1'b1;
            8'h4F: m[2] = 1'b1;
            8'h52: m[1] = 1'b1;
            8'h51: m[0] = 1'b1;
            8'h28, 8'h2C: m[8] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    assign rpt.ReportReady = (state_q == COLLECT);
    assign xfer            = rpt.ReportValid && rpt.ReportReady;
    assign commit_ok       = (state_q == COMMIT) && !discard_q;
    assign tmo_hit         = (tmo_q == TW'(TIMEOUT_CYCLES));

    assign Keycode    = key_q;
    assign StartPulse = sp_q;
    assign Overflow   = ovf_q;

    // State register and all datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= COLLECT;
            acc_q        <= '0;
            cnt_q        <= '0;
            discard_q    <= 1'b0;
            pending_q    <= '0;
            tmo_q        <= '0;
            prev_start_q <= 1'b0;
            key_q        <= '0;
            sp_q         <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef KEY_STICKY_EN
            last_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            discard_q    <= discard_d;
            pending_q    <= pending_d;
            tmo_q        <= tmo_d;
            prev_start_q <= prev_start_d;
            key_q        <= key_d;
            sp_q         <= sp_d;
            ovf_q        <= ovf_d;
`ifdef KEY_STICKY_EN
            last_q       <= last_d;
`endif
        end
    end

    // Next-state: report collection FSM, pending/timeout update, frame sampling.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        discard_d    = discard_q;
        pending_d    = pending_q;
        tmo_d        = tmo_q;
        prev_start_d = prev_start_q;
        key_d        = key_q;
        sp_d         = 1'b0;
        ovf_d        = ovf_q;
`ifdef KEY_STICKY_EN
        last_d       = last_q;
`endif

        case (state_q)
            COLLECT: begin
                if (!tmo_hit) tmo_d = tmo_q + 1'b1;
                if (xfer) begin
                    if (cnt_q == CW'(NUM_SLOTS)) begin
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = acc_q | map_key(rpt.ReportByte);
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (rpt.ReportByte == 8'h01) discard_d = 1'b1;
                    if (rpt.ReportLast) state_d = COMMIT;
                end
            end
            COMMIT: begin
                acc_d     = '0;
                cnt_d     = '0;
                discard_d = 1'b0;
                state_d   = COLLECT;
            end
            default: state_d = COLLECT;
        endcase

        // Frame sampling always reads pending_q, so a same-cycle commit or
        // timeout clear only becomes visible on the following frame.
`ifdef KEY_STICKY_EN
        if (FrameStart) pending_d = last_q;
        if (commit_ok) begin
            pending_d = (FrameStart ? 9'd0 : pending_q) | acc_q;
            last_d    = acc_q;
            tmo_d     = '0;
        end else if (tmo_hit) begin
            pending_d = '0;
            last_d    = '0;
        end
`else
        if (commit_ok) begin
            pending_d = acc_q;
            tmo_d     = '0;
        end else if (tmo_hit) begin
            pending_d = '0;
        end
`endif

        if (FrameStart) begin
            key_d        = pending_q[7:0];
            sp_d         = pending_q[8] && !prev_start_q;
            prev_start_d = pending_q[8];
        end
    end

endmodule

// File: tb/tb_key_mapper.sv
// Self-checking bench for key_mapper: a vector table of report/frame
// pairs, hand-written multi-cycle corner cases, then random reports
// checked against a transaction-level reference model.
module tb_key_mapper;

    localparam int unsigned NSLOT = 6;
    localparam int unsigned TMO   = 100;

    logic       Clk;
    logic       Reset_n;
    logic       FrameStart;
    logic [7:0] Keycode;
    logic       StartPulse;
    logic       Overflow;

    key_mapper_if bus ();

    key_mapper #(
        .NUM_SLOTS      (NSLOT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .rpt        (bus),
        .FrameStart (FrameStart),
        .Keycode    (Keycode),
        .StartPulse (StartPulse),
        .Overflow   (Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct packed {
        logic [31:0]     n;
        logic [0:9][7:0] b;
        logic [7:0]      key;
        logic            sp;
        logic            ovf;
    } vec_t;

    vec_t vecs [8];

    // Reference model state (transaction level).
    logic [8:0] m_pending;
    logic [8:0] m_last;
    logic       m_prev;
    logic       m_ovf;
    logic [7:0] pool [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int unsigned guard;
        guard = 0;
        while (bus.ReportReady !== 1'b1 && guard < 10) begin
            idle(1);
            guard++;
        end
        if (guard >= 10) begin
            total++;
            bad++;
            $display("FAIL ready_wait: got ReportReady=%b expected 1", bus.ReportReady);
        end
        bus.ReportValid = 1'b1;
        bus.ReportByte  = b;
        bus.ReportLast  = last;
        idle(1);
        bus.ReportValid = 1'b0;
        bus.ReportLast  = 1'b0;
        bus.ReportByte  = 8'h00;
    endtask

    task automatic send_report(input logic [0:9][7:0] b, input int unsigned n, input bit gaps);
        for (int unsigned i = 0; i < n; i++) begin
            send_byte(b[i], i == n - 1);
            if (gaps && $urandom_range(1, 0) == 1) idle(1);
        end
    endtask

    task automatic frame();
        FrameStart = 1'b1;
        idle(1);
        FrameStart = 1'b0;
    endtask

    function automatic logic [8:0] keymask(input logic [7:0] c);
        case (c)
            8'h04: return 9'h080;
            8'h07: return 9'h040;
            8'h1A: return 9'h020;
            8'h16: return 9'h010;
            8'h50: return 9'h008;
            8'h4F: return 9'h004;
            8'h52: return 9'h002;
            8'h51: return 9'h001;
            8'h28: return 9'h100;
            8'h2C: return 9'h100;
            default: return 9'h000;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:9][7:0] rb;
        logic [8:0]      rm;
        logic            disc;
        logic [7:0]      ek;
        logic            esp;
        int unsigned     k;
        int unsigned     n;

        vecs[0] = '{n: 6, b: {8'h04, 8'h52, 64'h0},                key: 8'h82, sp: 1'b0, ovf: 1'b0};
        vecs[1] = '{n: 1, b: {8'h28, 72'h0},                       key: 8'h00, sp: 1'b1, ovf: 1'b0};
        vecs[2] = '{n: 1, b: {8'h28, 72'h0},                       key: 8'h00, sp: 1'b0, ovf: 1'b0};
        vecs[3] = '{n: 1, b: {8'h07, 72'h0},                       key: 8'h40, sp: 1'b0, ovf: 1'b0};
        vecs[4] = '{n: 6, b: {{6{8'h01}}, 32'h0},                  key: 8'h40, sp: 1'b0, ovf: 1'b0};
        vecs[5] = '{n: 8, b: {8'h1A, 40'h0, 8'h50, 8'h16, 16'h0},  key: 8'h20, sp: 1'b0, ovf: 1'b1};
        vecs[6] = '{n: 2, b: {8'h50, 8'h4F, 64'h0},                key: 8'h0C, sp: 1'b0, ovf: 1'b1};
        vecs[7] = '{n: 2, b: {8'h2C, 8'h51, 64'h0},                key: 8'h01, sp: 1'b1, ovf: 1'b1};

        pool[0]  = 8'h04; pool[1]  = 8'h07; pool[2]  = 8'h1A; pool[3]  = 8'h16;
        pool[4]  = 8'h50; pool[5]  = 8'h4F; pool[6]  = 8'h52; pool[7]  = 8'h51;
        pool[8]  = 8'h28; pool[9]  = 8'h2C; pool[10] = 8'h00; pool[11] = 8'h00;
        pool[12] = 8'h05; pool[13] = 8'h29; pool[14] = 8'h01; pool[15] = 8'h53;

        Reset_n         = 1'b0;
        FrameStart      = 1'b0;
        bus.ReportValid = 1'b0;
        bus.ReportByte  = 8'h00;
        bus.ReportLast  = 1'b0;
        #22;
        chk("rst_keycode", 32'(Keycode), 32'h0);
        chk("rst_startpulse", 32'(StartPulse), 32'h0);
        chk("rst_overflow", 32'(Overflow), 32'h0);
        chk("rst_ready", 32'(bus.ReportReady), 32'h1);
        @(negedge Clk);
        Reset_n = 1'b1;
        idle(1);

        // Table-driven report/frame vectors.
        for (int i = 0; i < 8; i++) begin
            send_report(vecs[i].b, vecs[i].n, 1'b0);
            idle(1);
            frame();
            chk($sformatf("vec%0d_keycode", i), 32'(Keycode), 32'(vecs[i].key));
            chk($sformatf("vec%0d_startpulse", i), 32'(StartPulse), 32'(vecs[i].sp));
            chk($sformatf("vec%0d_overflow", i), 32'(Overflow), 32'(vecs[i].ovf));
            idle(1);
            chk($sformatf("vec%0d_pulse_end", i), 32'(StartPulse), 32'h0);
            chk($sformatf("vec%0d_key_hold", i), 32'(Keycode), 32'(vecs[i].key));
        end

        // FrameStart coincident with COMMIT samples the old report.
        send_report({8'h07, 72'h0}, 1, 1'b0);
        frame();
        chk("coinc_old_key", 32'(Keycode), 32'h01);
        chk("coinc_no_pulse", 32'(StartPulse), 32'h0);
        idle(1);
        frame();
        chk("coinc_new_key", 32'(Keycode), 32'h40);

        // Timeout releases keys.
        send_report({8'h51, 72'h0}, 1, 1'b0);
        idle(1);
        frame();
        chk("tmo_before", 32'(Keycode), 32'h01);
        idle(TMO + 20);
        frame();
        chk("tmo_after", 32'(Keycode), 32'h00);

        // Press and release inside one frame.
        send_report({8'h04, 72'h0}, 1, 1'b0);
        idle(1);
        send_report({8'h00, 72'h0}, 1, 1'b0);
        idle(1);
        frame();
`ifdef KEY_STICKY_EN
        chk("tap_frame1", 32'(Keycode), 32'h80);
`else
        chk("tap_frame1", 32'(Keycode), 32'h00);
`endif
        idle(1);
        frame();
        chk("tap_frame2", 32'(Keycode), 32'h00);

        // Reset in the middle of a report.
        send_report({8'h04, 72'h0}, 1, 1'b0);
        idle(1);
        frame();
        chk("prereset_key", 32'(Keycode), 32'h80);
        send_byte(8'h1A, 1'b0);
        send_byte(8'h16, 1'b0);
        send_byte(8'h28, 1'b0);
        Reset_n = 1'b0;
        #1;
        chk("midrst_keycode", 32'(Keycode), 32'h0);
        chk("midrst_startpulse", 32'(StartPulse), 32'h0);
        chk("midrst_overflow", 32'(Overflow), 32'h0);
        chk("midrst_ready", 32'(bus.ReportReady), 32'h1);
        @(negedge Clk);
        Reset_n = 1'b1;
        idle(2);
        chk("postrst_no_pulse", 32'(StartPulse), 32'h0);
        frame();
        chk("postrst_frame_key", 32'(Keycode), 32'h0);
        chk("postrst_frame_pulse", 32'(StartPulse), 32'h0);
        send_report({8'h4F, 72'h0}, 1, 1'b0);
        idle(1);
        frame();
        chk("postrst_report_key", 32'(Keycode), 32'h04);

        // Random reports against the reference model.
        m_pending = 9'h004;
        m_last    = 9'h004;
        m_prev    = 1'b0;
        m_ovf     = 1'b0;
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(2, 1);
            for (int unsigned r = 0; r < k; r++) begin
                n  = $urandom_range(8, 1);
                rb = '0;
                for (int unsigned j = 0; j < n; j++) begin
                    rb[j] = pool[$urandom_range(15, 0)];
                    // the closing report of each burst is always accepted,
                    // keeping gaps between good commits below the timeout
                    if (r == k - 1 && rb[j] == 8'h01) rb[j] = 8'h00;
                end
                send_report(rb, n, 1'b1);
                rm   = '0;
                disc = 1'b0;
                for (int unsigned j = 0; j < n; j++) begin
                    if (rb[j] == 8'h01) disc = 1'b1;
                    if (j < NSLOT) rm = rm | keymask(rb[j]);
                end
                if (n > NSLOT) m_ovf = 1'b1;
                if (!disc) begin
`ifdef KEY_STICKY_EN
                    m_pending = m_pending | rm;
                    m_last    = rm;
`else
                    m_pending = rm;
`endif
                end
            end
            idle(1);
            frame();
            ek     = m_pending[7:0];
            esp    = m_pending[8] && !m_prev;
            m_prev = m_pending[8];
`ifdef KEY_STICKY_EN
            m_pending = m_last;
`endif
            chk($sformatf("rnd%0d_keycode", it), 32'(Keycode), 32'(ek));
            chk($sformatf("rnd%0d_startpulse", it), 32'(StartPulse), 32'(esp));
            chk($sformatf("rnd%0d_overflow", it), 32'(Overflow), 32'(m_ovf));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
